// File: rtl/frogger_game_ctrl.sv
// Frogger game controller for the 8x8 LED matrix: button edge detection, game FSM,
// scrolling car lanes, frog movement, collision/goal detection and row-register output.
module frogger_game_ctrl #(
  parameter int                             DATAWIDTH_BUS       = 8,
  parameter int                             PRESCALER_DATAWIDTH = 23,
  parameter logic [PRESCALER_DATAWIDTH-1:0] LANE_PERIOD         = 23'd5000000
) (
  input  logic                     FROGGER_GAME_CTRL_CLOCK_50,
  input  logic                     FROGGER_GAME_CTRL_RESET_InLow,
  input  logic                     FROGGER_GAME_CTRL_start_In,
  input  logic                     FROGGER_GAME_CTRL_left_In,
  input  logic                     FROGGER_GAME_CTRL_right_In,
  input  logic                     FROGGER_GAME_CTRL_up_In,
  input  logic                     FROGGER_GAME_CTRL_down_In,
  output logic [DATAWIDTH_BUS-1:0] FROGGER_GAME_CTRL_data7_Out,
  output logic [DATAWIDTH_BUS-1:0] FROGGER_GAME_CTRL_data6_Out,
  output logic [DATAWIDTH_BUS-1:0] FROGGER_GAME_CTRL_data5_Out,
  output logic [DATAWIDTH_BUS-1:0] FROGGER_GAME_CTRL_data4_Out,
  output logic [DATAWIDTH_BUS-1:0] FROGGER_GAME_CTRL_data3_Out,
  output logic [DATAWIDTH_BUS-1:0] FROGGER_GAME_CTRL_data2_Out,
  output logic [DATAWIDTH_BUS-1:0] FROGGER_GAME_CTRL_data1_Out,
  output logic [DATAWIDTH_BUS-1:0] FROGGER_GAME_CTRL_data0_Out,
  output logic [1:0]               FROGGER_GAME_CTRL_state_Out,
  output logic [3:0]               FROGGER_GAME_CTRL_score_Out
);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_WIN = 2'b10, S_LOSE = 2'b11} state_t;

  // Rows 0 (home) and 7 (goal) are kept as empty lanes so lookups by y need no range guard.
  localparam logic [7:0][DATAWIDTH_BUS-1:0] LANE_RST =
    {8'h00, 8'h90, 8'h06, 8'h60, 8'h88, 8'h18, 8'hC0, 8'h00};

  // Button order: {start, up, down, left, right}
  localparam int B_START = 4, B_UP = 3, B_DOWN = 2, B_LEFT = 1, B_RIGHT = 0;

  state_t                              state_q;
  logic [3:0]                          score_q;
  logic [7:0][DATAWIDTH_BUS-1:0]       lanes_q, lanes_d;
  logic [2:0]                          x_q, x_d, y_q, y_d;
  logic [PRESCALER_DATAWIDTH-1:0]      cnt_q, cnt_d;
  logic [4:0]                          prev_q, btn, press;
  logic                                tick, goal, hit;
  logic [7:0][DATAWIDTH_BUS-1:0]       rows;

  assign btn   = {FROGGER_GAME_CTRL_start_In, FROGGER_GAME_CTRL_up_In, FROGGER_GAME_CTRL_down_In,
                  FROGGER_GAME_CTRL_left_In, FROGGER_GAME_CTRL_right_In};
  assign press = btn & ~prev_q;
  assign tick  = (cnt_q == LANE_PERIOD - 1'b1);
  assign goal  = (y_q == 3'd7);
  assign hit   = lanes_q[y_q][x_q];

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    lanes_d = lanes_q;
    if (tick) begin
      for (int i = 1; i <= 6; i++) begin
        if (i % 2 == 1) lanes_d[i] = {lanes_q[i][DATAWIDTH_BUS-2:0], lanes_q[i][DATAWIDTH_BUS-1]};
        else            lanes_d[i] = {lanes_q[i][0], lanes_q[i][DATAWIDTH_BUS-1:1]};
      end
    end
    x_d = x_q;
    y_d = y_q;
    if (press[B_UP]) begin
      if (y_q != 3'd7) y_d = y_q + 3'd1;
    end else if (press[B_DOWN]) begin
      if (y_q != 3'd0) y_d = y_q - 3'd1;
    end else if (press[B_LEFT]) begin
      if (x_q != 3'd7) x_d = x_q + 3'd1;
    end else if (press[B_RIGHT]) begin
      if (x_q != 3'd0) x_d = x_q - 3'd1;
    end
  end

  always_ff @(posedge FROGGER_GAME_CTRL_CLOCK_50 or negedge FROGGER_GAME_CTRL_RESET_InLow) begin
    if (!FROGGER_GAME_CTRL_RESET_InLow) begin
      state_q <= S_IDLE;
      score_q <= '0;
      lanes_q <= LANE_RST;
      x_q     <= 3'd3;
      y_q     <= 3'd0;
      cnt_q   <= '0;
      prev_q  <= '0;
    end else begin
      prev_q <= btn;
      unique case (state_q)
        S_IDLE: if (press[B_START]) begin
          state_q <= S_PLAY;
          cnt_q   <= '0;
        end
        // Outcome uses the registered frog/lanes; tick and move still land on the leaving edge.
        S_PLAY: begin
          cnt_q   <= cnt_d;
          lanes_q <= lanes_d;
          x_q     <= x_d;
          y_q     <= y_d;
          if (goal) begin
            state_q <= S_WIN;
            score_q <= score_q + 4'd1;
          end else if (hit) begin
            state_q <= S_LOSE;
          end
        end
        S_WIN, S_LOSE: if (press[B_START]) begin
          state_q <= S_PLAY;
          lanes_q <= LANE_RST;
          x_q     <= 3'd3;
          y_q     <= 3'd0;
          cnt_q   <= '0;
          if (state_q == S_LOSE) score_q <= '0;
        end
      endcase
    end
  end

  for (genvar r = 0; r < 8; r++) begin : g_row
    assign rows[r] = (state_q == S_WIN) ? {DATAWIDTH_BUS{1'b1}} :
                     lanes_q[r] | ((y_q == 3'(r)) ? (DATAWIDTH_BUS'(1) << x_q) : '0);
  end

  assign FROGGER_GAME_CTRL_data0_Out = rows[0];
  assign FROGGER_GAME_CTRL_data1_Out = rows[1];
  assign FROGGER_GAME_CTRL_data2_Out = rows[2];
  assign FROGGER_GAME_CTRL_data3_Out = rows[3];
  assign FROGGER_GAME_CTRL_data4_Out = rows[4];
  assign FROGGER_GAME_CTRL_data5_Out = rows[5];
  assign FROGGER_GAME_CTRL_data6_Out = rows[6];
  assign FROGGER_GAME_CTRL_data7_Out = rows[7];
  assign FROGGER_GAME_CTRL_state_Out = state_q;
  assign FROGGER_GAME_CTRL_score_Out = score_q;

endmodule
